rca_accum_seq: RTL and testbench

//  Sequencing stage wrapped around the combinational N-bit ripple-carry adder (top_RCA).

---
 rtl/rca_accum_seq.sv | 116 +++++++++++
 tb/tb_rca_accum_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rca_accum_seq.sv
// Sequencer around an external ripple-carry adder: accepts operands, holds the adder
// inputs for a settle window, accumulates the sum and emits it with a sticky overflow flag.
module rca_accum_seq #(
    parameter int unsigned W          = 8,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_sub,
    input  logic         in_last,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_cin,
    input  logic [W-1:0] add_s,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_ovf
);

    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [W-1:0]       op_q, op_d;
    logic               sub_q, sub_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    // Next-state and datapath updates; op_q holds the operand already inverted for subtraction
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        sub_d   = sub_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d    = in_sub ? ~in_data : in_data;
                    sub_d   = in_sub;
                    last_d  = in_last;
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    acc_d   = add_s;
                    ovf_d   = ovf_q | (sub_q ? ~add_cout : add_cout);
                    state_d = last_q ? OUT : IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            OUT: begin
                if (out_valid_q && out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            op_q        <= '0;
            sub_q       <= 1'b0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            sub_q       <= sub_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;
    assign add_a     = acc_q;
    assign add_b     = op_q;
    assign add_cin   = sub_q;

endmodule

// File: tb/tb_rca_accum_seq.sv
// Directed bench for rca_accum_seq with a behavioural ripple-carry adder attached.
module tb_rca_accum_seq;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_sub;
    logic         in_last;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W-1:0] add_s;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + 9'(add_cin);

    rca_accum_seq #(.W(W), .SETTLE_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sub(in_sub), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand; exp_a is the accumulator the adder should see during settle
    task automatic send(input logic [W-1:0] d, input logic sub, input logic last,
                        input logic [W-1:0] exp_a);
        logic [W-1:0] exp_b;
        int n;
        exp_b = sub ? ~d : d;
        in_valid = 1'b1; in_data = d; in_sub = sub; in_last = last;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; in_data = 8'hXX; in_sub = 1'b0; in_last = 1'b0;
        for (int c = 0; c < 2; c++) begin
            check("settle_in_ready", 32'(in_ready), 32'd0);
            check("settle_add_a", 32'(add_a), 32'(exp_a));
            check("settle_add_b", 32'(add_b), 32'(exp_b));
            check("settle_add_cin", 32'(add_cin), 32'(sub));
            tick();
        end
        check("post_in_ready", 32'(in_ready), 32'(!last));
        check("post_out_valid", 32'(out_valid), 32'(last));
    endtask

    task automatic recv(input logic [W-1:0] exp_d, input logic exp_ovf);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("out_valid_wait", 32'(out_valid), 32'd1);
        check("out_data", 32'(out_data), 32'(exp_d));
        check("out_ovf", 32'(out_ovf), 32'(exp_ovf));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("done_out_valid", 32'(out_valid), 32'd0);
        check("done_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_last = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_add", {add_a, add_b, 7'd0, add_cin, 8'd0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: two adds
        send(8'h20, 1'b0, 1'b0, 8'h00);
        send(8'h05, 1'b0, 1'b1, 8'h20);
        recv(8'h25, 1'b0);

        // 2: three adds
        send(8'h41, 1'b0, 1'b0, 8'h00);
        send(8'h16, 1'b0, 1'b0, 8'h41);
        send(8'h09, 1'b0, 1'b1, 8'h57);
        recv(8'h60, 1'b0);

        // 3: carry sets sticky flag, cleared for next sum
        send(8'h8F, 1'b0, 1'b0, 8'h00);
        send(8'h2F, 1'b0, 1'b0, 8'h8F);
        send(8'hA0, 1'b0, 1'b1, 8'hBE);
        recv(8'h5E, 1'b1);
        send(8'h03, 1'b0, 1'b1, 8'h00);
        recv(8'h03, 1'b0);

        // 4: subtraction, no borrow then borrow
        send(8'h48, 1'b0, 1'b0, 8'h00);
        send(8'h48, 1'b1, 1'b1, 8'h48);
        recv(8'h00, 1'b0);
        send(8'h05, 1'b0, 1'b0, 8'h00);
        send(8'h0A, 1'b1, 1'b1, 8'h05);
        recv(8'hFB, 1'b1);

        // 5: backpressure holds the result
        send(8'h33, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", 32'(out_data), 32'h33);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        recv(8'h33, 1'b0);

        // 6: reset mid-settle aborts the sum
        send(8'h10, 1'b0, 1'b0, 8'h00);
        in_valid = 1'b1; in_data = 8'h20; in_sub = 1'b0; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        check("pre_rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_add", {add_a, add_b, 7'd0, add_cin, 8'd0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        send(8'h07, 1'b0, 1'b1, 8'h00);
        recv(8'h07, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
